// File: rtl/stage_sequencer_if.sv
// Handshake/status bundle between the stage sequencer and the datapath stage blocks.
// Latency: none (wires only); the master modport is the sequencer side.
// Backpressure: per-stage stage_ready bits stretch the active stage; no other flow control.
// Ports: run, halt_req, stage_ready (and step when SEQ_SINGLE_STEP_EN is defined) into the
//        sequencer; stage_en, stage_idx, instr_retire, retired_count, cycle_count, busy,
//        halted, timeout_err out of it.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32
);
    logic                          run;
    logic                          halt_req;
    logic [NUM_STAGES-1:0]         stage_ready;
`ifdef SEQ_SINGLE_STEP_EN
    logic                          step;
`endif
    logic [NUM_STAGES-1:0]         stage_en;
    logic [$clog2(NUM_STAGES)-1:0] stage_idx;
    logic                          instr_retire;
    logic [CNT_W-1:0]              retired_count;
    logic [CNT_W-1:0]              cycle_count;
    logic                          busy;
    logic                          halted;
    logic                          timeout_err;

`ifdef SEQ_SINGLE_STEP_EN
    modport master (
        input  run, halt_req, stage_ready, step,
        output stage_en, stage_idx, instr_retire, retired_count, cycle_count,
               busy, halted, timeout_err
    );
    modport slave (
        output run, halt_req, stage_ready, step,
        input  stage_en, stage_idx, instr_retire, retired_count, cycle_count,
               busy, halted, timeout_err
    );
`else
    modport master (
        input  run, halt_req, stage_ready,
        output stage_en, stage_idx, instr_retire, retired_count, cycle_count,
               busy, halted, timeout_err
    );
    modport slave (
        output run, halt_req, stage_ready,
        input  stage_en, stage_idx, instr_retire, retired_count, cycle_count,
               busy, halted, timeout_err
    );
`endif
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: one-hot stage enables, run/halt control, counters, stall watchdog.
// Latency: all outputs registered; run seen in IDLE gives stage 0 on the next cycle; min NUM_STAGES cycles/instr.
// Backpressure: a stage holds while its stage_ready bit is low, up to MAX_WAIT cycles, then ERROR.
// Ports: clk, reset (async, active high), bus (stage_sequencer_if.master).
// Optional: define SEQ_SINGLE_STEP_EN to add bus.step, which launches one instruction from IDLE when run=0.
module stage_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int MAX_WAIT   = 15
) (
    input  logic               clk,
    input  logic               reset,
    stage_sequencer_if.master  bus
);
    localparam int IDX_W  = $clog2(NUM_STAGES);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W-1:0]  LAST_STAGE = IDX_W'(NUM_STAGES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    stage_q, stage_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                halt_pending_q, halt_pending_d;
    logic                single_q, single_d;
    logic                retire_d;
    logic                halt_now;
    logic                cur_ready;
    logic                step_launch;

    logic [NUM_STAGES-1:0] stage_en_q;
    logic [IDX_W-1:0]      stage_idx_q;
    logic                  instr_retire_q;
    logic [CNT_W-1:0]      retired_count_q;
    logic [CNT_W-1:0]      cycle_count_q;
    logic                  busy_q;
    logic                  halted_q;
    logic                  timeout_err_q;

    // A step only launches from IDLE while run is low; with run high the
    // normal continuous path takes over.
`ifdef SEQ_SINGLE_STEP_EN
    assign step_launch = bus.step & ~bus.run;
`else
    assign step_launch = 1'b0;
`endif

    // A halt request seen on the very edge of a boundary must win, so the
    // decision uses the request as well as the sticky flag.
    assign halt_now  = halt_pending_q | bus.halt_req;
    assign cur_ready = bus.stage_ready[stage_q];

    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        wait_d         = wait_q;
        single_d       = single_q;
        retire_d       = 1'b0;
        halt_pending_d = halt_pending_q | (bus.halt_req & (state_q != S_ERROR));

        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    if (halt_now) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d  = S_RUN;
                        stage_d  = '0;
                        wait_d   = '0;
                        single_d = 1'b0;
                    end
                end else if (step_launch) begin
                    state_d  = S_RUN;
                    stage_d  = '0;
                    wait_d   = '0;
                    single_d = 1'b1;
                end
            end

            S_RUN: begin
                if (cur_ready) begin
                    wait_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        // Instruction boundary: retire, then pick what comes next.
                        retire_d = 1'b1;
                        stage_d  = '0;
                        single_d = 1'b0;
                        if (halt_now) begin
                            state_d = S_HALTED;
                        end else if (!bus.run || single_q) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stage_d = stage_q + IDX_W'(1);
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    // This is the MAX_WAIT-th consecutive cycle without ready.
                    state_d = S_ERROR;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            stage_q         <= '0;
            wait_q          <= '0;
            halt_pending_q  <= 1'b0;
            single_q        <= 1'b0;
            stage_en_q      <= '0;
            stage_idx_q     <= '0;
            instr_retire_q  <= 1'b0;
            retired_count_q <= '0;
            cycle_count_q   <= '0;
            busy_q          <= 1'b0;
            halted_q        <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            wait_q         <= wait_d;
            halt_pending_q <= halt_pending_d;
            single_q       <= single_d;

            // Outputs are decoded from the next state so they are true flops
            // aligned with the state they describe.
            stage_en_q     <= (state_d == S_RUN) ? (NUM_STAGES'(1) << stage_d) : '0;
            stage_idx_q    <= (state_d == S_RUN) ? stage_d : '0;
            busy_q         <= (state_d == S_RUN);
            halted_q       <= (state_d == S_HALTED);
            timeout_err_q  <= (state_d == S_ERROR);
            instr_retire_q <= retire_d;

            if (retire_d) begin
                retired_count_q <= retired_count_q + CNT_W'(1);
            end
            // Counts the cycle that just ended if it was spent in RUN.
            if (state_q == S_RUN) begin
                cycle_count_q <= cycle_count_q + CNT_W'(1);
            end
        end
    end

    assign bus.stage_en      = stage_en_q;
    assign bus.stage_idx     = stage_idx_q;
    assign bus.instr_retire  = instr_retire_q;
    assign bus.retired_count = retired_count_q;
    assign bus.cycle_count   = cycle_count_q;
    assign bus.busy          = busy_q;
    assign bus.halted        = halted_q;
    assign bus.timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios with literal expectations plus randomized traffic.
// Latency: inputs driven 2ns after the rising edge; outputs compared on the falling edge.
// Backpressure: stage_ready patterns stretch stages and provoke the watchdog.
module tb_stage_sequencer;
    localparam int NS = 5;
    localparam int CW = 32;
    localparam int MW = 15;

    logic          clk;
    logic          reset;
    logic          run;
    logic          halt_req;
    logic [NS-1:0] stage_ready;
`ifdef SEQ_SINGLE_STEP_EN
    logic          step;
`endif

    int checks   = 0;
    int failures = 0;

    stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    assign bus.run         = run;
    assign bus.halt_req    = halt_req;
    assign bus.stage_ready = stage_ready;
`ifdef SEQ_SINGLE_STEP_EN
    assign bus.step        = step;
`endif

    stage_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 running, 2 halted, 3 error
    int            m_mode = 0;
    int            m_stage = 0;
    int            m_zeros = 0;
    bit            m_halt = 0;
    bit            m_single = 0;
    bit            m_retire = 0;
    logic [CW-1:0] m_retired = '0;
    logic [CW-1:0] m_cycles = '0;
    bit            m_hnow;
    bit            m_step;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_stage = 0; m_zeros = 0; m_halt = 0; m_single = 0;
            m_retire = 0; m_retired = '0; m_cycles = '0;
        end else begin
            m_hnow = m_halt || halt_req;
            if (halt_req && m_mode != 3) m_halt = 1;
            m_retire = 0;
`ifdef SEQ_SINGLE_STEP_EN
            m_step = step;
`else
            m_step = 0;
`endif
            if (m_mode == 1) m_cycles = m_cycles + 1;
            if (m_mode == 0) begin
                if (run) begin
                    if (m_hnow) m_mode = 2;
                    else begin m_mode = 1; m_stage = 0; m_zeros = 0; m_single = 0; end
                end else if (m_step) begin
                    m_mode = 1; m_stage = 0; m_zeros = 0; m_single = 1;
                end
            end else if (m_mode == 1) begin
                if (stage_ready[m_stage]) begin
                    m_zeros = 0;
                    if (m_stage == NS - 1) begin
                        m_retire  = 1;
                        m_retired = m_retired + 1;
                        m_stage   = 0;
                        if (m_hnow) m_mode = 2;
                        else if (!run || m_single) m_mode = 0;
                        m_single = 0;
                    end else begin
                        m_stage = m_stage + 1;
                    end
                end else begin
                    m_zeros = m_zeros + 1;
                    if (m_zeros >= MW) m_mode = 3;
                end
            end
        end
    end

    // Single compare process: every falling edge, DUT vs model.
    always @(negedge clk) begin
        chk("cyc_stage_en", 64'(bus.stage_en), (m_mode == 1) ? 64'(1) << m_stage : 64'(0));
        chk("cyc_stage_idx", 64'(bus.stage_idx), (m_mode == 1) ? 64'(m_stage) : 64'(0));
        chk("cyc_retire", 64'(bus.instr_retire), 64'(m_retire));
        chk("cyc_retired_count", 64'(bus.retired_count), 64'(m_retired));
        chk("cyc_cycle_count", 64'(bus.cycle_count), 64'(m_cycles));
        chk("cyc_busy", 64'(bus.busy), 64'(m_mode == 1));
        chk("cyc_halted", 64'(bus.halted), 64'(m_mode == 2));
        chk("cyc_timeout", 64'(bus.timeout_err), 64'(m_mode == 3));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        run = 0; halt_req = 0; stage_ready = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 0;
`endif
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2 reset = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        logic [NS-1:0] en_rec [13];
        logic          ret_rec [13];
        int            nret, cnt, nbusy, cnt3;
        bit            seen;
        logic [CW-1:0] cc_snap, rc_snap;

        reset = 1;
        clear_inputs();
        #3;
        chk("reset_stage_en", 64'(bus.stage_en), 64'(0));
        chk("reset_counts", 64'(bus.retired_count) | 64'(bus.cycle_count), 64'(0));
        chk("reset_flags", {61'(0), bus.busy, bus.halted, bus.timeout_err}, 64'(0));
        @(posedge clk); #2 reset = 0;

        // Basic run: all ready, 12 cycles.
        run = 1; stage_ready = '1;
        nret = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            en_rec[c]  = bus.stage_en;
            ret_rec[c] = bus.instr_retire;
            nret += int'(bus.instr_retire);
        end
        chk("basic_en_c1", 64'(en_rec[1]), 64'h01);
        chk("basic_en_c2", 64'(en_rec[2]), 64'h02);
        chk("basic_en_c5", 64'(en_rec[5]), 64'h10);
        chk("basic_retire_c6", 64'(ret_rec[6]), 64'd1);
        chk("basic_retire_c11", 64'(ret_rec[11]), 64'd1);
        chk("basic_retire_total", 64'(nret), 64'd2);
        chk("basic_retired_count", 64'(bus.retired_count), 64'd2);
        run = 0;
        cnt = 0;
        while (bus.busy && cnt < 20) begin cyc(); cnt++; end
        chk("basic_return_idle", 64'(bus.busy), 64'd0);

        // Stretched stage 3: ready low for 4 sampled cycles.
        do_reset();
        run = 1; stage_ready = 5'b10111;
        nbusy = 0; cnt3 = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            cyc();
            run = 0;
            if (bus.busy) nbusy++;
            if (bus.stage_en == 5'b01000) cnt3++;
            if (cnt3 == 5) stage_ready[3] = 1'b1;
            if (bus.instr_retire) seen = 1;
        end
        chk("stretch_seen_retire", 64'(seen), 64'd1);
        chk("stretch_stage3_cycles", 64'(cnt3), 64'd5);
        chk("stretch_instr_cycles", 64'(nbusy), 64'd9);
        chk("stretch_no_timeout", 64'(bus.timeout_err), 64'd0);

        // Watchdog: stage 1 never ready.
        do_reset();
        run = 1; stage_ready = 5'b11101;
        cnt = 0;
        for (int c = 0; c < 40 && !bus.timeout_err; c++) begin
            cyc();
            if (bus.stage_en == 5'b00010) cnt++;
        end
        chk("wdog_error", 64'(bus.timeout_err), 64'd1);
        chk("wdog_wait_cycles", 64'(cnt), 64'd15);
        chk("wdog_stage_en_zero", 64'(bus.stage_en), 64'd0);
        chk("wdog_cycle_count", 64'(bus.cycle_count), 64'd16);
        cc_snap = bus.cycle_count; rc_snap = bus.retired_count;
        stage_ready = '1;
        repeat (4) cyc();
        chk("wdog_cycles_frozen", 64'(bus.cycle_count), 64'(cc_snap));
        chk("wdog_retired_frozen", 64'(bus.retired_count), 64'(rc_snap));
        chk("wdog_still_error", 64'(bus.timeout_err), 64'd1);

        // Watchdog boundary: ready arrives on the 15th waiting cycle.
        do_reset();
        run = 1; stage_ready = 5'b11101;
        cnt = 0;
        for (int c = 0; c < 40 && bus.stage_en != 5'b00100 && !bus.timeout_err; c++) begin
            cyc();
            if (bus.stage_en == 5'b00010) cnt++;
            if (cnt == 15) stage_ready[1] = 1'b1;
        end
        chk("wdog_edge_cycles", 64'(cnt), 64'd15);
        chk("wdog_edge_advanced", 64'(bus.stage_en), 64'h04);
        chk("wdog_edge_no_error", 64'(bus.timeout_err), 64'd0);
        run = 0;
        cnt = 0;
        while (bus.busy && cnt < 20) begin cyc(); cnt++; end

        // Halt pulse during stage 2.
        do_reset();
        run = 1; stage_ready = '1;
        cnt = 0;
        while (bus.stage_en != 5'b00100 && cnt < 20) begin cyc(); cnt++; end
        halt_req = 1;
        cyc();
        halt_req = 0;
        seen = 0; cnt = 0;
        while (!bus.halted && cnt < 20) begin
            cyc(); cnt++;
            if (bus.instr_retire) seen = 1;
        end
        chk("halt_retire_seen", 64'(seen), 64'd1);
        chk("halt_halted", 64'(bus.halted), 64'd1);
        chk("halt_retired_count", 64'(bus.retired_count), 64'd1);
        chk("halt_stage_en", 64'(bus.stage_en), 64'd0);

        // Run dropped at stage 1, then resumed.
        do_reset();
        run = 1; stage_ready = '1;
        cnt = 0;
        while (bus.stage_en != 5'b00010 && cnt < 20) begin cyc(); cnt++; end
        run = 0;
        cnt = 0;
        while (!bus.instr_retire && cnt < 20) begin cyc(); cnt++; end
        chk("pause_retire", 64'(bus.instr_retire), 64'd1);
        chk("pause_idle", 64'(bus.busy), 64'd0);
        run = 1;
        cyc();
        chk("pause_resume_stage0", 64'(bus.stage_en), 64'h01);
        chk("pause_retired_kept", 64'(bus.retired_count), 64'd1);

        // Asynchronous reset in stage 3.
        do_reset();
        run = 1; stage_ready = '1;
        cnt = 0;
        while (bus.stage_en != 5'b01000 && cnt < 20) begin cyc(); cnt++; end
        #1 reset = 1;
        #1;
        chk("areset_stage_en", 64'(bus.stage_en), 64'd0);
        chk("areset_outputs", {bus.retired_count, bus.cycle_count}, 64'd0);
        chk("areset_flags", {59'(0), bus.instr_retire, bus.stage_idx == 0 ? 1'b0 : 1'b1,
                             bus.busy, bus.halted, bus.timeout_err}, 64'd0);
        cyc();
        reset = 0;
        cyc();
        chk("areset_restart_stage0", 64'(bus.stage_en), 64'h01);
        chk("areset_no_retire", 64'(bus.retired_count), 64'd0);

`ifdef SEQ_SINGLE_STEP_EN
        // Single step from IDLE.
        do_reset();
        run = 0; stage_ready = '1; step = 1;
        nbusy = 0; nret = 0;
        cyc();
        step = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (bus.busy) nbusy++;
            nret += int'(bus.instr_retire);
        end
        chk("step_stage_cycles", 64'(nbusy), 64'd5);
        chk("step_retires", 64'(nret), 64'd1);
        chk("step_retired_count", 64'(bus.retired_count), 64'd1);
        chk("step_idle", 64'(bus.busy), 64'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 149) begin
                reset = 1;
                cyc();
                reset = 0;
            end
            run         = ($urandom_range(0, 9) != 0);
            halt_req    = ($urandom_range(0, 299) == 0);
            stage_ready = NS'($urandom | $urandom);
`ifdef SEQ_SINGLE_STEP_EN
            step        = ($urandom_range(0, 3) == 0);
`endif
            cyc();
        end

        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised multicycle stage sequencer. Replaces the fixed chain of delayed clock phases with one clock plus one-hot stage enables: fetch, instruction memory, register read, memory, register write.
- Each stage may stretch over several cycles through a per-stage ready handshake.
- Sits at datapath top level, driving the enables of the Fetch, Decode, Execute, Memory and Writeback blocks.
- Provides run/halt control, retire and cycle counters, and a stall watchdog.

Parameters:
- NUM_STAGES, 5, number of sequenced stages (min 2).
- CNT_W, 32, width of cycle and retire counters.
- MAX_WAIT, 15, max cycles a stage may wait for ready before timeout (min 1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level; 1 = execute instructions continuously.
- halt_req  in  1  pulse/level; stop permanently at next instruction boundary.
- stage_ready  in  NUM_STAGES  per-stage completion; bit k meaningful only while stage_en[k]=1.
- stage_en  out  NUM_STAGES  one-hot active stage enable; all zero when not RUN.
- stage_idx  out  $clog2(NUM_STAGES)  index of active stage; 0 when not RUN.
- instr_retire  out  1  one-cycle pulse when last stage completes.
- retired_count  out  CNT_W  retired instructions, wraps mod 2^CNT_W.
- cycle_count  out  CNT_W  cycles spent in RUN, wraps mod 2^CNT_W.
- busy  out  1  1 while in RUN.
- halted  out  1  1 in HALTED.
- timeout_err  out  1  1 in ERROR.

Behaviour:
- Reset is asynchronous. While reset=1: state=IDLE and every output is 0, including stage_en, stage_idx, both counters, halt_pending and wait_cnt.
- States: IDLE, RUN, HALTED, ERROR. All outputs are registered.
- IDLE:
  - run=1 and no halt_pending: go to RUN with stage 0 the next cycle.
  - run=1 with halt_pending: go to HALTED.
- RUN, stage k:
  - stage_en = 1<<k, stage_idx = k, busy = 1; cycle_count increments every RUN cycle.
  - stage_ready[k]=1 sampled at a clock edge: next cycle is stage k+1 and wait_cnt is cleared.
  - A stage with ready already high lasts exactly 1 cycle. The minimum instruction length is NUM_STAGES cycles.
- Last stage (k=NUM_STAGES-1) with ready:
  - instr_retire pulses in the following cycle; retired_count increments in that same cycle.
  - Boundary decision, in priority order: halt_pending -> HALTED; else run=0 -> IDLE; else stage 0.
  - run=0 in mid-instruction does not abort; the current instruction completes first.
- Watchdog:
  - wait_cnt counts consecutive cycles in the current stage with ready=0.
  - If wait_cnt reaches MAX_WAIT with ready still 0, the next state is ERROR. Ready arriving on that same edge wins: the stage advances.
- halt_pending:
  - Set by halt_req=1 in any state except ERROR; sticky; cleared only by reset.
  - halt_req together with run=0 at a boundary: HALTED wins.
- HALTED and ERROR are terminal until reset: stage_en=0, counters frozen, halted=1 or timeout_err=1 respectively.
- Reset asserted mid-instruction: immediate return to IDLE, no retire pulse, counters cleared.
- stage_ready bits of inactive stages are ignored.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input port `step` (1 bit).
  - In IDLE with run=0, a step=1 sample launches exactly one instruction through all stages, then returns to IDLE. It retires normally, and halt_pending still takes priority at the boundary.
  - step is ignored outside IDLE. step=1 held continuously runs back-to-back instructions, one per boundary, each with a single IDLE cycle between them.
- Undefined: no step port; IDLE exits only via run.

Test Plan:
- Basic run: reset, run=1, all stage_ready=1 for 12 cycles -> stage_en walks 00001..10000 each cycle; instr_retire pulses at cycles 6 and 11; retired_count=2.
- Stretched stage: stage_ready[3] held 0 for 4 cycles -> stage_en=01000 for 5 cycles; no timeout; instruction takes 9 cycles.
- Watchdog, MAX_WAIT=15: stage_ready[1] held 0 -> timeout_err=1 after 15 wait cycles; stage_en=0; counters frozen. Ready asserted on cycle 15 instead -> advance, no error.
- Halt/pause: halt_req pulse at stage 2 -> instruction completes, retire pulse, then halted=1. Separately, run dropped at stage 1 -> finish, IDLE; run=1 again -> resumes at stage 0 with retired_count preserved.
- Async reset mid-instruction at stage 3 -> all outputs 0 within the same cycle, no retire pulse; run=1 restarts at stage 0.
- SEQ_SINGLE_STEP_EN: run=0, one step pulse -> exactly 5 stage cycles, one retire, back to IDLE; retired_count=1. Without the macro, the bench compiles without `step`.
